mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 src_a  input  WIDTH  rs operand (multiplicand / dividend).
REQ-008 src_b  input  WIDTH  rt operand (multiplier / divisor).
REQ-009 mthi_we, mtlo_we  input  1 each  direct-write strobes for HI and LO.
REQ-010 wdata  input  WIDTH  data for the mthi/mtlo writes.
REQ-011 hi, lo  output  WIDTH each  architectural HI/LO registers, always driven.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  one-cycle pulse, high in the first cycle new HI/LO results are visible.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and FIX; any other encoding SHALL return to IDLE.
REQ-015 IDLE with start=1 at edge E0: latch op, |src_a|, |src_b| and the operand signs, clear the iteration counter, go to CALC.
- Signed ops take magnitudes; unsigned ops use operands as-is.
REQ-016 CALC SHALL perform exactly one radix-2 step per edge, on edges E1..E(WIDTH).
- Multiply: shift-add into a 2*WIDTH accumulator.
- Divide: restoring shift-subtract.
- After the WIDTH-th step, go to FIX.
REQ-017 FIX at edge E(WIDTH+1) SHALL:
- Apply sign correction: the product is negative when the signs differ; the quotient is negative when the signs differ; the remainder takes the dividend's sign.
- Write HI and LO.
- Return to IDLE.
REQ-018 Result mapping SHALL be:
- Multiply: HI = upper WIDTH bits of the product, LO = lower WIDTH bits.
- Divide: LO = quotient, HI = remainder.
REQ-019 busy SHALL be 1 in every cycle between E0 and E(WIDTH+1), i.e. for WIDTH+1 cycles, and 0 otherwise.
REQ-020 done SHALL be registered, 1 for exactly the cycle following E(WIDTH+1), and 0 otherwise.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 mthi_we / mtlo_we in IDLE SHALL write wdata to hi / lo at the next edge; while busy=1 they SHALL be ignored.
REQ-023 start together with mthi_we/mtlo_we in IDLE: both SHALL take effect; the later result overwrites HI/LO.
REQ-024 Divide by zero SHALL raise no exception and take the same latency, with HI = src_a and LO = all ones.
REQ-025 DIV of the most negative value by -1 SHALL wrap: LO = 0x80000000, HI = 0 (WIDTH=32).
REQ-026 hi and lo SHALL hold their values in all cycles except the FIX edge, mthi/mtlo writes and reset.

Reset
REQ-027 rst=1 at an edge SHALL force:
- state IDLE, counter 0;
- hi = 0, lo = 0;
- busy = 0, done = 0.
REQ-028 rst takes priority over start, mthi_we, mtlo_we and any in-flight operation.
REQ-029 rst during CALC/FIX SHALL abort the operation, with no done pulse and no late HI/LO update.

Structure
REQ-030 The shared package mips_pkg SHALL hold the md_op_t enum (MULT, MULTU, DIV, DIVU) and the md_state_t enum (IDLE, CALC, FIX).
REQ-031 One sub-module, md_step, SHALL contain the combinational single-iteration datapath (add or subtract/compare, shift), instantiated once.
REQ-032 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done high exactly 33 cycles after the start edge; busy high for 33 cycles.
REQ-034 MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); then DIVU 100 / 0 -> HI=0x00000064, LO=0xFFFFFFFF.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 Start a MULTU, pulse start again at cycle 5 and rst at cycle 10 -> second start ignored; after the reset edge hi=lo=0 and busy=0; no done ever pulses.
REQ-038 mthi_we with wdata=0x12345678 in IDLE -> hi=0x12345678 next cycle; mtlo_we during busy -> lo unchanged until FIX.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the multiply/divide unit.
// Holds the operation and FSM state encodings.
package mips_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_t;

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Ports: is_div selects restoring divide vs shift-add multiply;
//        acc_in/acc_out are the 2*WIDTH accumulator, operand is the
//        multiplicand (multiply) or divisor (divide).
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_sub;
    logic             fits;

    always_comb begin
        // Multiply: accumulator is {partial product, remaining multiplier bits}.
        sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]};
        if (acc_in[0]) begin
            sum = sum + {1'b0, operand};
        end

        // Divide: accumulator is {remainder, remaining dividend / quotient bits}.
        shifted = acc_in[2*WIDTH-1:WIDTH-1];
        fits    = (shifted >= {1'b0, operand});
        // When the divisor fits the difference is below 2^WIDTH.
        rem_sub = shifted[WIDTH-1:0] - operand;

        if (is_div) begin
            if (fits) begin
                acc_out = {rem_sub, acc_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit (one bit per cycle).
// Ports: clk/rst (sync, active high), start/op/src_a/src_b launch an op,
//        mthi_we/mtlo_we/wdata write HI/LO directly, hi/lo/busy/done out.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_t          state_q, state_d;
    md_op_t             op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               b_zero_q, b_zero_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] step_acc;
    logic               in_signed;
    logic               in_sa;
    logic               in_sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               res_signed;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    md_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div (op_q[1]),
        .acc_in (acc_q),
        .operand(opnd_q),
        .acc_out(step_acc)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        // MULT and DIV (op[0]==0) are the signed forms.
        in_signed = ~op[0];
        in_sa     = in_signed & src_a[WIDTH-1];
        in_sb     = in_signed & src_b[WIDTH-1];
        mag_a     = in_sa ? (~src_a + 1'b1) : src_a;
        mag_b     = in_sb ? (~src_b + 1'b1) : src_b;

        res_signed = ~op_q[0];
        prod = acc_q;
        if (res_signed && (sign_a_q ^ sign_b_q)) begin
            prod = ~acc_q + 1'b1;
        end
        quot = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        if (res_signed && (sign_a_q ^ sign_b_q)) begin
            quot = ~acc_q[WIDTH-1:0] + 1'b1;
        end
        if (res_signed && sign_a_q) begin
            rem = ~acc_q[2*WIDTH-1:WIDTH] + 1'b1;
        end
        // Remainder already equals src_a on divide by zero.
        if (b_zero_q) begin
            quot = '1;
        end

        case (state_q)
            IDLE: begin
                if (mthi_we) begin
                    hi_d = wdata;
                end
                if (mtlo_we) begin
                    lo_d = wdata;
                end
                if (start) begin
                    op_d     = md_op_t'(op);
                    sign_a_d = in_sa;
                    sign_b_d = in_sb;
                    b_zero_d = (src_b == '0);
                    cnt_d    = '0;
                    state_d  = CALC;
                    if (op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_q[1]) begin
                    hi_d = rem;
                    lo_d = quot;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sbq[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .mthi_we(mthi_we),
        .mtlo_we(mtlo_we),
        .wdata  (wdata),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done got=1 expected=0");
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_hi"}, {32'h0, hi}, {32'h0, e.hi});
                    chk({e.name, "_lo"}, {32'h0, lo}, {32'h0, e.lo});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic start_op(input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input bit push,
                            input logic [31:0] eh, input logic [31:0] el,
                            input string nm);
        exp_t e;
        @(negedge clk);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        if (push) begin
            e.hi = eh;
            e.lo = el;
            e.name = nm;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // off = negedges already observed since the start edge (all busy).
    task automatic wait_done(input string nm, input int off);
        int n  = off;
        int nb = off;
        bit got = 0;
        while (n < 60 && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1;
            else if (busy) nb++;
        end
        chk({nm, "_done_seen"}, 64'(got), 64'd1);
        chk({nm, "_latency"}, 64'(n - 1), 64'd33);
        chk({nm, "_busy_cycles"}, 64'(nb), 64'd33);
    endtask

    initial begin
        int dcnt;
        int hchg;
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        src_a = '0;
        src_b = '0;
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", {32'h0, hi}, 64'h0);
        chk("rst_lo", {32'h0, lo}, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        rst = 1'b0;

        // Direct HI write in IDLE.
        @(negedge clk);
        mthi_we = 1'b1;
        wdata = 32'h1234_5678;
        @(posedge clk);
        #1 mthi_we = 1'b0;
        @(negedge clk);
        chk("mthi_hi", {32'h0, hi}, 64'h1234_5678);
        chk("mthi_lo", {32'h0, lo}, 64'h0);

        // MULT -3 x 7 with an ignored mtlo during busy.
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1,
                 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        repeat (3) @(negedge clk);
        mtlo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 mtlo_we = 1'b0;
        @(negedge clk);
        chk("mtlo_busy_lo", {32'h0, lo}, 64'h0);
        wait_done("mult_neg", 4);

        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
                 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        wait_done("multu_max", 0);

        start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1,
                 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        wait_done("div_neg", 0);

        start_op(2'b11, 32'd100, 32'd0, 1,
                 32'h0000_0064, 32'hFFFF_FFFF, "divu_zero");
        wait_done("divu_zero", 0);

        start_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1,
                 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero_neg");
        wait_done("div_zero_neg", 0);

        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1,
                 32'h0, 32'h8000_0000, "div_ovf");
        wait_done("div_ovf", 0);

        start_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1,
                 32'h4000_0000, 32'h0, "mult_min");
        wait_done("mult_min", 0);

        // Start and mthi together: mthi lands first, result overwrites.
        @(negedge clk);
        op = 2'b01;
        src_a = 32'd3;
        src_b = 32'd5;
        start = 1'b1;
        mthi_we = 1'b1;
        wdata = 32'hAAAA_5555;
        sbq.push_back('{hi: 32'h0, lo: 32'hF, name: "multu_mthi"});
        @(posedge clk);
        #1 begin
            start = 1'b0;
            mthi_we = 1'b0;
        end
        @(negedge clk);
        chk("start_mthi_hi", {32'h0, hi}, 64'hAAAA_5555);
        wait_done("multu_mthi", 1);

        // Abort: second start at cycle 5 ignored, rst at cycle 10.
        start_op(2'b01, 32'h0000_1234, 32'h0000_5678, 0, 0, 0, "abort");
        dcnt = 0;
        repeat (4) @(negedge clk);
        if (done) dcnt++;
        op = 2'b11;
        src_a = 32'd9;
        src_b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_hi", {32'h0, hi}, 64'h0);
        chk("abort_lo", {32'h0, lo}, 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        hchg = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
            if (hi != 0 || lo != 0) hchg++;
        end
        chk("abort_no_done", 64'(dcnt), 64'h0);
        chk("abort_no_update", 64'(hchg), 64'h0);

        start_op(2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, "divu_after");
        wait_done("divu_after", 0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
